// File: rtl/serial_full_sub_if.sv
// serial_full_sub_if: request/result bundle for the bit-serial subtractor.
//   start, a, b, bin : request side, driven by the master
//   busy, done       : status, driven by the slave
//   d, bo, zero      : registered result, driven by the slave
interface serial_full_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bo, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bo, zero
  );
endinterface

// File: rtl/serial_full_sub.sv
// serial_full_sub: bit-serial subtractor computing {bo,d} = a - b - bin,
// one bit per clock, LSB first.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of serial_full_sub_if
//              start/a/b/bin sampled in IDLE; busy high in SHIFT;
//              done pulses one cycle in DONE; d/bo/zero hold until next DONE.
// WIDTH must match the WIDTH of the connected interface.
module serial_full_sub #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_full_sub_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;
  logic             zero_q, zero_d;

  // Full-subtractor cell on the current LSB of the shifting operands.
  logic diff, br_n;
  assign diff = a_q[0] ^ b_q[0] ^ br_q;
  assign br_n = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    d_d     = d_q;
    bo_d    = bo_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          sr_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        br_d = br_n;
        // Result enters at the MSB so bit i lands at position i after WIDTH shifts.
        sr_d            = sr_q >> 1;
        sr_d[WIDTH-1]   = diff;
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d     = sr_d;
          bo_d    = br_n;
          zero_d  = (sr_d == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.d    = d_q;
  assign bus.bo   = bo_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_serial_full_sub.sv
// tb_serial_full_sub: directed bench for serial_full_sub at WIDTH=8 and WIDTH=1.
module tb_serial_full_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_full_sub_if #(.WIDTH(8)) bus8 ();
  serial_full_sub_if #(.WIDTH(1)) bus1 ();

  serial_full_sub #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_full_sub #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  // Start one WIDTH=8 operation and wait for done. n = negedge samples after
  // the accepting edge until done (8 expected), bc = samples with busy high.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int n, output int bc);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    n = 0; bc = 0;
    while (bus8.done !== 1'b1 && n < 30) begin
      if (bus8.busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus8.busy, bus8.done, bus8.d, bus8.bo, bus8.zero} !== 11'h0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b d=%h bo=%b zero=%b expected all 0",
               bus8.busy, bus8.done, bus8.d, bus8.bo, bus8.zero);
    end
    checks++;
    if ({bus1.busy, bus1.done, bus1.d, bus1.bo, bus1.zero} !== 5'h0) begin
      errors++;
      $display("FAIL reset1: got %b expected 00000",
               {bus1.busy, bus1.done, bus1.d, bus1.bo, bus1.zero});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n, bc;
    do_op8(8'h05, 8'h03, 1'b0, n, bc);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", n); end
    checks++;
    if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
    checks++;
    if (bus8.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b expected 0", bus8.busy); end
    checks++;
    if ({bus8.d, bus8.bo, bus8.zero} !== {8'h02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: got d=%h bo=%b zero=%b expected d=02 bo=0 zero=0",
               bus8.d, bus8.bo, bus8.zero);
    end
    @(negedge clk);
    checks++;
    if (bus8.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", bus8.done); end
    checks++;
    if (bus8.d !== 8'h02) begin errors++; $display("FAIL basic_hold: got %h expected 02", bus8.d); end
  endtask

  task automatic test_held_start;
    int n, dones;
    @(negedge clk);
    bus8.a = 8'h5A; bus8.b = 8'h5A; bus8.bin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    n = 0; dones = 0;
    // Toggle start and scramble operands while busy; none of it may matter.
    while (bus8.done !== 1'b1 && n < 30) begin
      bus8.start = n[0];
      bus8.a = 8'hFF ^ 8'(n);
      bus8.b = 8'h00 | 8'(n);
      bus8.bin = ~n[0];
      @(negedge clk);
      n++;
    end
    bus8.start = 1'b0;
    checks++;
    if (n !== 8) begin errors++; $display("FAIL held_latency: got %0d expected 8", n); end
    checks++;
    if ({bus8.d, bus8.bo, bus8.zero} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL held_result: got d=%h bo=%b zero=%b expected d=00 bo=0 zero=1",
               bus8.d, bus8.bo, bus8.zero);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL held_single_done: got %0d extra active cycles expected 0", dones); end
  endtask

  task automatic test_borrow;
    int n, bc;
    do_op8(8'h03, 8'h05, 1'b0, n, bc);
    checks++;
    if (n !== 8 || {bus8.d, bus8.bo, bus8.zero} !== {8'hFE, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL borrow_neg: got n=%0d d=%h bo=%b zero=%b expected n=8 d=fe bo=1 zero=0",
               n, bus8.d, bus8.bo, bus8.zero);
    end
    // Back-to-back: next start offered right after done.
    do_op8(8'h00, 8'h00, 1'b1, n, bc);
    checks++;
    if (n !== 8 || {bus8.d, bus8.bo, bus8.zero} !== {8'hFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL borrow_bin: got n=%0d d=%h bo=%b zero=%b expected n=8 d=ff bo=1 zero=0",
               n, bus8.d, bus8.bo, bus8.zero);
    end
  endtask

  task automatic test_abort;
    int n, bc, dones;
    @(negedge clk);
    bus8.a = 8'h05; bus8.b = 8'h03; bus8.bin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus8.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", bus8.busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.d, bus8.bo, bus8.zero} !== 11'h0) begin
      errors++;
      $display("FAIL abort_async_clear: got busy=%b done=%b d=%h bo=%b zero=%b expected all 0",
               bus8.busy, bus8.done, bus8.d, bus8.bo, bus8.zero);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    do_op8(8'hFF, 8'h01, 1'b0, n, bc);
    checks++;
    if (n !== 8 || bc !== 8) begin
      errors++;
      $display("FAIL abort_fresh_latency: got n=%0d busy=%0d expected 8 8", n, bc);
    end
    checks++;
    if ({bus8.d, bus8.bo, bus8.zero} !== {8'hFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_fresh_result: got d=%h bo=%b zero=%b expected d=fe bo=0 zero=0",
               bus8.d, bus8.bo, bus8.zero);
    end
  endtask

  task automatic test_width1;
    // {bo,d} for (a,b,bin) = 000 .. 111
    logic [1:0] exp_tab [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(negedge clk);
      bus1.a = v[2]; bus1.b = v[1]; bus1.bin = v[0]; bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      checks++;
      if (bus1.busy !== 1'b1) begin errors++; $display("FAIL w1_busy[%0d]: got %b expected 1", i, bus1.busy); end
      @(negedge clk);
      checks++;
      if (bus1.done !== 1'b1 || {bus1.bo, bus1.d} !== exp_tab[i]) begin
        errors++;
        $display("FAIL w1_truth[%0d]: got done=%b bo,d=%b expected done=1 bo,d=%b",
                 i, bus1.done, {bus1.bo, bus1.d}, exp_tab[i]);
      end
    end
  endtask

  initial begin
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
    test_reset;
    test_basic;
    test_held_start;
    test_borrow;
    test_abort;
    test_width1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_full_sub.md
SERIAL_FULL_SUB -- requirements
Module: serial_full_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (WIDTH >= 1).
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin a subtraction.
REQ-006 SHALL have port a, input, WIDTH, minuend, sampled on the accepted start.
REQ-007 SHALL have port b, input, WIDTH, subtrahend, sampled on the accepted start.
REQ-008 SHALL have port bin, input, 1, borrow-in, sampled on the accepted start.
REQ-009 SHALL have port busy, output, 1, high while bits are being processed.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-011 SHALL have port d, output, WIDTH, difference result.
REQ-012 SHALL have port bo, output, 1, borrow-out of the MSB stage.
REQ-013 SHALL have port zero, output, 1, high when the final d is all zeros.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-015 IDLE SHALL go to SHIFT on the clk edge where start=1, loading a, b and bin into internal registers and clearing the bit counter.
REQ-016 SHALL ignore start while in SHIFT or DONE; no restart and no operand reload.
REQ-017 Each SHIFT edge SHALL process one bit, LSB first: diff = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-018 Each SHIFT edge SHALL shift diff into an internal result shift register MSB-side, so that after WIDTH bits bit i holds diff_i.
REQ-019 SHALL go from SHIFT to DONE on the WIDTH-th SHIFT edge, counter value WIDTH-1; the counter SHALL be clog2(WIDTH)-bit, minimum 1, and SHALL never wrap.
REQ-020 On entry to DONE, d SHALL load the shift register, bo SHALL load the final borrow, and zero SHALL load (result == 0).
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 busy SHALL be 1 exactly in SHIFT.
REQ-023 Latency: done SHALL be high in the cycle after WIDTH+1 rising edges counted from the accepting edge; a new start SHALL be accepted the cycle after done.
REQ-024 d, bo and zero SHALL hold their last values through IDLE and the following SHIFT, changing only on entry to DONE or on reset.
REQ-025 Arithmetic SHALL equal {bo,d} = {1'b0,a} - {1'b0,b} - bin modulo 2^(WIDTH+1), with bo=1 iff a < b + bin.

Reset
REQ-026 rst=1 SHALL force, asynchronously, state=IDLE, busy=0, done=0, d=0, bo=0, zero=0, and clear the internal registers and counter.
REQ-027 rst asserted in SHIFT SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL run a fresh full WIDTH-cycle operation.

Verification
REQ-028 WIDTH=8: a=0x05, b=0x03, bin=0, one-cycle start -> busy high 8 cycles, done on the 9th edge, d=0x02, bo=0, zero=0.
REQ-029 WIDTH=8: a=0x03, b=0x05, bin=0 -> d=0xFE, bo=1, zero=0; next, a=0x00, b=0x00, bin=1 -> d=0xFF, bo=1.
REQ-030 WIDTH=8: a=0x5A, b=0x5A, bin=0 -> d=0x00, bo=0, zero=1; held start and start pulses during busy -> exactly one done, operands unchanged.
REQ-031 WIDTH=1: all 8 (a,b,bin) combinations, 2-cycle spacing -> {bo,d} matches the full-subtractor truth table (d=a^b^bin; bo=~a&b | ~(a^b)&bin).
REQ-032 WIDTH=8: rst pulsed on the 4th SHIFT cycle -> busy, done, d, bo and zero all 0 immediately with no done; then a=0xFF, b=0x01, bin=0 -> d=0xFE, bo=0.
